// File: rtl/sbox_builder.sv
// Collects distinct bytes into a 2**W-entry substitution table in arrival order.
// One-cycle registered echo of each newly accepted byte; never backpressures, duplicates are dropped.
module sbox_builder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tvalid,
    input  logic [W-1:0] V,
    output logic         valid,
    output logic [W-1:0] V_out,
    output logic         done_sbox
);
    localparam int         DEPTH    = 2**W;
    localparam logic [W:0] CNT_LAST = (W+1)'(DEPTH - 1);

    logic [DEPTH-1:0] used_q, used_d;
    logic [W:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     v_out_q, v_out_d;
    logic             done_q, done_d;
    logic [W-1:0]     s_q [DEPTH];
    logic             accept;

    // Duplicate check is a direct bitmap lookup, so the decision lands in the same cycle.
    assign accept = tvalid && !used_q[V] && !done_q;

    always_comb begin
        used_d  = used_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        v_out_d = v_out_q;
        done_d  = done_q;
        if (accept) begin
            used_d[V] = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            valid_d   = 1'b1;
            v_out_d   = V;
            if (cnt_q == CNT_LAST) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            used_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            v_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            used_q  <= used_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            v_out_q <= v_out_d;
            done_q  <= done_d;
        end
    end

    // Table contents are left stale across reset; cnt and used define what is live.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            s_q[cnt_q[W-1:0]] <= V;
        end
    end

    assign valid     = valid_q;
    assign V_out     = v_out_q;
    assign done_sbox = done_q;

endmodule

// File: tb/tb_sbox_builder.sv
// Directed bench for sbox_builder: reset, gapped and back-to-back fills, duplicates, post-done and mid-fill reset.
module tb_sbox_builder;
    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         tvalid;
    logic [W-1:0] V;
    logic         valid;
    logic [W-1:0] V_out;
    logic         done_sbox;

    int vectors;
    int miscompares;

    sbox_builder #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tvalid    (tvalid),
        .V         (V),
        .valid     (valid),
        .V_out     (V_out),
        .done_sbox (done_sbox)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tvalid  = 1'b0;
        V       = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        vectors++;
        if (V_out !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_v_out: got %0d want 0", V_out);
        end
        vectors++;
        if (done_sbox !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", done_sbox);
        end
        vectors++;
        if (dut.cnt_q !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q);
        end
    endtask

    task automatic test_descending_gapped();
        logic [W-1:0] exp_s;
        for (int v = 255; v >= 0; v--) begin
            tvalid = 1'b1;
            V      = W'(v);
            tick();
            tvalid = 1'b0;
            vectors++;
            if (valid !== 1'b1 || V_out !== W'(v)) begin
                miscompares++;
                $display("FAIL desc_pulse v=%0d: got valid=%b V_out=%0d want valid=1 V_out=%0d",
                         v, valid, V_out, v);
            end
            vectors++;
            if (done_sbox !== (v == 0)) begin
                miscompares++;
                $display("FAIL desc_done v=%0d: got %b want %b", v, done_sbox, (v == 0));
            end
            tick();
            vectors++;
            if (valid !== 1'b0) begin
                miscompares++;
                $display("FAIL desc_gap v=%0d: got valid=%b want 0", v, valid);
            end
        end
        for (int k = 0; k < 256; k++) begin
            exp_s = W'(255 - k);
            vectors++;
            if (dut.s_q[k] !== exp_s) begin
                miscompares++;
                $display("FAIL desc_table S[%0d]: got %0d want %0d", k, dut.s_q[k], exp_s);
            end
        end
    endtask

    task automatic test_duplicates();
        logic [W-1:0] seq   [4];
        logic         exp_v [4];
        logic [W-1:0] exp_o [4];
        seq   = '{8'd5, 8'd5, 8'd7, 8'd5};
        exp_v = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_o = '{8'd5, 8'd5, 8'd7, 8'd7};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1;
            V      = seq[i];
            tick();
            vectors++;
            if (valid !== exp_v[i] || V_out !== exp_o[i]) begin
                miscompares++;
                $display("FAIL dup_step%0d: got valid=%b V_out=%0d want valid=%b V_out=%0d",
                         i, valid, V_out, exp_v[i], exp_o[i]);
            end
        end
        tvalid = 1'b0;
        vectors++;
        if (dut.cnt_q !== 9'd2) begin
            miscompares++;
            $display("FAIL dup_cnt: got %0d want 2", dut.cnt_q);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            tvalid = 1'b1;
            V      = W'(i);
            tick();
            vectors++;
            if (valid !== 1'b1 || V_out !== W'(i) || done_sbox !== (i == 255)) begin
                miscompares++;
                $display("FAIL b2b i=%0d: got valid=%b V_out=%0d done=%b want valid=1 V_out=%0d done=%b",
                         i, valid, V_out, done_sbox, i, (i == 255));
            end
        end
        tvalid = 1'b0;
    endtask

    task automatic test_after_done();
        tvalid = 1'b1;
        V      = 8'd42;
        tick();
        tick();
        tvalid = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_done_valid: got %b want 0", valid);
        end
        vectors++;
        if (done_sbox !== 1'b1) begin
            miscompares++;
            $display("FAIL post_done_sticky: got %b want 1", done_sbox);
        end
        vectors++;
        if (V_out !== 8'd255) begin
            miscompares++;
            $display("FAIL post_done_v_out: got %0d want 255", V_out);
        end
    endtask

    task automatic test_reset_midfill();
        logic [W-1:0] b;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tvalid = 1'b1;
            V      = W'(3 * i + 1);
            tick();
        end
        tvalid = 1'b0;
        vectors++;
        if (dut.cnt_q !== 9'd10) begin
            miscompares++;
            $display("FAIL midfill_cnt_before: got %0d want 10", dut.cnt_q);
        end
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            b      = W'(3 * i + 1);
            tvalid = 1'b1;
            V      = b;
            tick();
            vectors++;
            if (valid !== 1'b1 || V_out !== b || done_sbox !== 1'b0) begin
                miscompares++;
                $display("FAIL midfill_refeed i=%0d: got valid=%b V_out=%0d done=%b want valid=1 V_out=%0d done=0",
                         i, valid, V_out, done_sbox, b);
            end
        end
        tvalid = 1'b0;
        vectors++;
        if (dut.s_q[0] !== 8'd1 || dut.s_q[9] !== 8'd28) begin
            miscompares++;
            $display("FAIL midfill_table: got S0=%0d S9=%0d want S0=1 S9=28", dut.s_q[0], dut.s_q[9]);
        end
        vectors++;
        if (dut.cnt_q !== 9'd10) begin
            miscompares++;
            $display("FAIL midfill_cnt_after: got %0d want 10", dut.cnt_q);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        tvalid      = 1'b0;
        V           = '0;
        test_reset();
        test_descending_gapped();
        test_duplicates();
        test_back_to_back();
        test_after_done();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
